// File: rtl/cpu_run_ctrl.sv
// CPU run/halt sequencer: start flush, stall merge, single-step, PC breakpoint, halt cause, cycle counter.
// stall/stall_1shot are combinational from state and stall_req; every other output comes from registers.
module cpu_run_ctrl #(
  parameter int NSRC      = 4,
  parameter int STEP_W    = 16,
  parameter int CYC_W     = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_start,
  input  logic              quit_cmd,
  input  logic              step_cmd,
  input  logic [STEP_W-1:0] step_num,
  input  logic              bp_en,
  input  logic [31:2]       bp_adr,
  input  logic [31:2]       pc_ex,
  input  logic [NSRC-1:0]   stall_req,
  output logic              stall,
  output logic              stall_1shot,
  output logic              stall_dly,
  output logic              rst_pipe,
  output logic              running,
  output logic [1:0]        halt_cause,
  output logic [CYC_W-1:0]  cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_STEP,
    S_HALT
  } state_t;

  localparam int            FW         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_QUIT = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  state_t              state, state_nxt;
  logic [FW-1:0]       flush_cnt, flush_nxt;
  logic [STEP_W-1:0]   step_cnt, step_nxt;
  logic [1:0]          cause_nxt;
  logic [CYC_W-1:0]    cyc_nxt;
  logic                adv;
  logic                bp_hit;
  logic [STEP_W-1:0]   step_ld;

  assign running     = (state == S_RUN) || (state == S_STEP);
  assign stall       = running ? |stall_req : 1'b1;
  assign stall_1shot = stall & ~stall_dly;
  assign rst_pipe    = (state == S_FLUSH);
  assign adv         = running & ~stall;
  assign bp_hit      = bp_en & adv & (pc_ex == bp_adr);
  assign step_ld     = (step_num == '0) ? STEP_W'(1) : step_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flush_cnt  <= '0;
      step_cnt   <= '0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
      stall_dly  <= 1'b1;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_nxt;
      step_cnt   <= step_nxt;
      halt_cause <= cause_nxt;
      cycle_cnt  <= cyc_nxt;
      stall_dly  <= stall;
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    step_nxt  = step_cnt;
    cause_nxt = halt_cause;
    cyc_nxt   = cycle_cnt;

    if (adv) begin
      cyc_nxt = cycle_cnt + CYC_W'(1);
      if (state == S_STEP) begin
        step_nxt = step_cnt - STEP_W'(1);
      end
    end

    case (state)
      S_IDLE, S_HALT: begin
        if (cpu_start) begin
          // A nonzero step count left here selects STEP instead of RUN once the flush ends.
          state_nxt = S_FLUSH;
          flush_nxt = '0;
          cyc_nxt   = '0;
          cause_nxt = CAUSE_NONE;
          step_nxt  = step_cmd ? step_ld : '0;
        end else if (step_cmd && (state == S_HALT)) begin
          state_nxt = S_STEP;
          step_nxt  = step_ld;
        end
      end

      S_FLUSH: begin
        if (quit_cmd) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_QUIT;
        end else if (flush_cnt == FLUSH_LAST) begin
          state_nxt = (step_cnt != '0) ? S_STEP : S_RUN;
        end else begin
          flush_nxt = flush_cnt + FW'(1);
        end
      end

      S_RUN, S_STEP: begin
        if (quit_cmd) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_QUIT;
        end else if (bp_hit) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_BP;
        end else if ((state == S_STEP) && adv && (step_cnt == STEP_W'(1))) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_STEP;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Cycle-by-cycle bench for cpu_run_ctrl: per-cycle stimulus rows carry hand-derived expected outputs,
// pushed to a scoreboard when driven and popped at the negedge; a CYC_W=4 twin checks counter wrap.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_start, quit_cmd, step_cmd, bp_en;
  logic [15:0] step_num;
  logic [31:2] bp_adr, pc_ex;
  logic [3:0]  stall_req;

  logic        stall, stall_1shot, stall_dly, rst_pipe, running;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;

  logic        w_stall, w_stall_1shot, w_stall_dly, w_rst_pipe, w_running;
  logic [1:0]  w_halt_cause;
  logic [3:0]  w_cycle_cnt;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .cpu_start(cpu_start), .quit_cmd(quit_cmd), .step_cmd(step_cmd),
    .step_num(step_num), .bp_en(bp_en), .bp_adr(bp_adr), .pc_ex(pc_ex), .stall_req(stall_req),
    .stall(stall), .stall_1shot(stall_1shot), .stall_dly(stall_dly), .rst_pipe(rst_pipe),
    .running(running), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.CYC_W(4)) dut_w (
    .clk(clk), .rst(rst), .cpu_start(cpu_start), .quit_cmd(quit_cmd), .step_cmd(step_cmd),
    .step_num(step_num), .bp_en(bp_en), .bp_adr(bp_adr), .pc_ex(pc_ex), .stall_req(stall_req),
    .stall(w_stall), .stall_1shot(w_stall_1shot), .stall_dly(w_stall_dly), .rst_pipe(w_rst_pipe),
    .running(w_running), .halt_cause(w_halt_cause), .cycle_cnt(w_cycle_cnt)
  );

  typedef struct packed {
    logic        st;
    logic        s1;
    logic        sd;
    logic        rp;
    logic        rn;
    logic [1:0]  ca;
    logic [31:0] cy;
  } obs_t;

  typedef struct {
    logic        rst;
    logic        start;
    logic        quit;
    logic        step;
    logic [15:0] num;
    logic [3:0]  req;
    logic        bpen;
    logic [31:2] pc;
    obs_t        exp;
  } stim_t;

  localparam logic [31:2] BP_WORD = 30'h10;  // byte address 0x40

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t mk(input logic st, input logic s1, input logic sd, input logic rp,
                              input logic rn, input logic [1:0] ca, input logic [31:0] cy);
    obs_t o;
    o.st = st; o.s1 = s1; o.sd = sd; o.rp = rp; o.rn = rn; o.ca = ca; o.cy = cy;
    return o;
  endfunction

  function automatic stim_t sv(input logic r, input logic start, input logic quit, input logic step,
                               input logic [15:0] num, input logic [3:0] req, input logic bpen,
                               input logic [31:2] pc, input obs_t exp);
    stim_t s;
    s.rst = r; s.start = start; s.quit = quit; s.step = step; s.num = num;
    s.req = req; s.bpen = bpen; s.pc = pc; s.exp = exp;
    return s;
  endfunction

  function automatic obs_t snap();
    return mk(stall, stall_1shot, stall_dly, rst_pipe, running, halt_cause, cycle_cnt);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("stall=%b 1shot=%b dly=%b rst_pipe=%b running=%b cause=%0d cyc=%0d",
                     o.st, o.s1, o.sd, o.rp, o.rn, o.ca, o.cy);
  endfunction

  // Drives one cycle of inputs, queues its expected outputs and moves to the sampling edge.
  task automatic apply(input stim_t s);
    rst       = s.rst;
    cpu_start = s.start;
    quit_cmd  = s.quit;
    step_cmd  = s.step;
    step_num  = s.num;
    stall_req = s.req;
    bp_en     = s.bpen;
    pc_ex     = s.pc;
    exp_q.push_back(s.exp);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t t[$];
    rst = 1'b1; cpu_start = 1'b0; quit_cmd = 1'b0; step_cmd = 1'b0; step_num = '0;
    stall_req = '0; bp_en = 1'b0; pc_ex = '0; bp_adr = BP_WORD;
    repeat (2) @(posedge clk);
    #1;
    t.push_back(sv(1, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 1, 5, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    t.push_back(sv(0, 0, 1, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_run();
    stim_t t[$];
    t.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0)));
    for (int k = 1; k <= 5; k++) t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, k)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL start_run[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    stim_t t[$];
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0100, 0, 0, mk(1, 1, 0, 0, 1, 0, 6)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0100, 0, 0, mk(1, 0, 1, 0, 1, 0, 6)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0100, 0, 0, mk(1, 0, 1, 0, 1, 0, 6)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(0, 0, 1, 0, 1, 0, 6)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(0, 0, 0, 0, 1, 0, 7)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_breakpoint();
    stim_t t[$];
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0001, 1, BP_WORD, mk(1, 1, 0, 0, 1, 0, 8)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0001, 1, BP_WORD, mk(1, 0, 1, 0, 1, 0, 8)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 1, BP_WORD, mk(0, 0, 1, 0, 1, 0, 8)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 1, BP_WORD, mk(1, 1, 0, 0, 0, 2, 9)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(1, 0, 1, 0, 0, 2, 9)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL breakpoint[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_step();
    stim_t t[$];
    t.push_back(sv(0, 0, 0, 1, 3, 4'b0000, 0, 0, mk(1, 0, 1, 0, 0, 2, 9)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(0, 0, 1, 0, 1, 2, 9)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b1000, 0, 0, mk(1, 1, 0, 0, 1, 2, 10)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(0, 0, 1, 0, 1, 2, 10)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(0, 0, 0, 0, 1, 2, 11)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(1, 1, 0, 0, 0, 3, 12)));
    t.push_back(sv(0, 0, 0, 1, 0, 4'b0000, 0, 0, mk(1, 0, 1, 0, 0, 3, 12)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(0, 0, 1, 0, 1, 3, 12)));
    t.push_back(sv(0, 0, 0, 0, 0, 4'b0000, 0, 0, mk(1, 1, 0, 0, 0, 3, 13)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL step[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_quit();
    stim_t t[$];
    t.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 3, 13)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0)));
    t.push_back(sv(0, 0, 1, 0, 0, 0, 1, BP_WORD, mk(0, 0, 0, 0, 1, 0, 1)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 1, 2)));
    t.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 2)));
    t.push_back(sv(0, 0, 1, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 0)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL quit[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap_and_reset();
    stim_t t[$];
    t.push_back(sv(0, 1, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 1, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0)));
    for (int k = 1; k <= 16; k++) t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, k)));
    t.push_back(sv(1, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 17)));
    t.push_back(sv(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0)));
    foreach (t[i]) begin
      obs_t got, want;
      apply(t[i]);
      got = snap();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      if (i >= 3) begin
        checks++;
        if (w_cycle_cnt !== want.cy[3:0]) begin
          errors++;
          $display("FAIL wrap4[%0d]: cycle_cnt got %0d, want %0d", i, w_cycle_cnt, want.cy[3:0]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_stall();
    test_breakpoint();
    test_step();
    test_quit();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
